glip_uart_tx_scheduler: RTL and testbench

Egress scheduler for the UART backend. It shares the single UART transmitter between the host-bound data stream, taken from the egress CDC FIFO, and credit-return control frames for ingress flow control. Data bytes equal to the escape value are doubled. Credit grants are accumulated and emitted as 3-byte escape frames on byte boundaries. The block sits in the I/O clock domain between the egress CDC FIFO and the UART transmit module.

---
 rtl/glip_uart_pkg.sv | 16 +
 rtl/glip_uart_tx_scheduler_credit_acc.sv | 52 +++++
 rtl/glip_uart_tx_scheduler.sv | 136 +++++++++++++
 tb/tb_glip_uart_tx_scheduler.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/glip_uart_pkg.sv
// Shared constants and FSM state type for the GLIP UART egress path.
package glip_uart_pkg;

  localparam logic [7:0] ESC              = 8'hFE;
  localparam int         CREDIT_FRAME_MAX = 16383;

  typedef enum logic [2:0] {
    IDLE,
    D_BYTE,
    D_DUP,
    C_ESC,
    C_HI,
    C_LO
  } tx_state_e;

endpackage

// File: rtl/glip_uart_tx_scheduler_credit_acc.sv
// Saturating credit accumulator: snapshot/subtract port, threshold compare, non-zero flag.
// Update is single-cycle; an add in the snapshot cycle lands in the same update.
module glip_uart_credit_acc
  import glip_uart_pkg::*;
#(
  parameter int CREDIT_WIDTH     = 16,
  parameter int CREDIT_THRESHOLD = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    add_i,
  input  logic [CREDIT_WIDTH-1:0] inc_i,
  input  logic                    snap_i,
  output logic [13:0]             amt_o,
  output logic                    pending_o,
  output logic                    nz_o
);

  localparam int AW = (CREDIT_WIDTH > 14) ? CREDIT_WIDTH : 14;

  logic [CREDIT_WIDTH-1:0] acc_q, acc_d;
  logic [AW-1:0]           acc_ext;
  logic [AW-1:0]           amt_ext;
  logic [CREDIT_WIDTH:0]   sum;

  // One spare bit on the sum: acc - amt never underflows, so the MSB flags overflow only.
  always_comb begin
    acc_ext = AW'(acc_q);
    amt_ext = (acc_ext > AW'(CREDIT_FRAME_MAX)) ? AW'(CREDIT_FRAME_MAX) : acc_ext;
    sum     = {1'b0, acc_q};
    if (snap_i) begin
      sum = sum - (CREDIT_WIDTH + 1)'(amt_ext);
    end
    if (add_i) begin
      sum = sum + {1'b0, inc_i};
    end
    acc_d = sum[CREDIT_WIDTH] ? '1 : sum[CREDIT_WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign amt_o     = amt_ext[13:0];
  assign pending_o = (acc_q >= CREDIT_WIDTH'(CREDIT_THRESHOLD));
  assign nz_o      = |acc_q;

endmodule

// File: rtl/glip_uart_tx_scheduler.sv
// UART egress scheduler: ESC-doubled data bytes and 3-byte credit frames share one transmitter.
// Byte starts one cycle after acceptance; host CTS gating under GLIP_UART_TX_SCHED_CTS_EN.
module glip_uart_tx_scheduler
  import glip_uart_pkg::*;
#(
  parameter int CREDIT_WIDTH     = 16,
  parameter int CREDIT_THRESHOLD = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [7:0]              data_in,
  input  logic                    data_valid,
  output logic                    data_ready,
  input  logic                    credit_add,
  input  logic [CREDIT_WIDTH-1:0] credit_inc,
  output logic [7:0]              tx_data,
  output logic                    tx_enable,
  input  logic                    tx_done,
  input  logic                    uart_cts_n,
  output logic                    busy
);

  tx_state_e   state_q, state_d;
  logic [7:0]  byte_q, byte_d;
  logic [13:0] amt_q, amt_d;
  logic        last_q, last_d;
  logic        tx_en_q, tx_en_d;

  logic        snap;
  logic        pending;
  logic        acc_nz;
  logic [13:0] snap_amt;
  logic        cts_ok;
  logic        gap;

`ifdef GLIP_UART_TX_SCHED_CTS_EN
  logic [1:0] cts_sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cts_sync_q <= 2'b00;
    end else begin
      cts_sync_q <= {cts_sync_q[0], ~uart_cts_n};
    end
  end

  assign cts_ok = cts_sync_q[1];
`else
  logic unused_cts;
  assign unused_cts = uart_cts_n;
  assign cts_ok     = 1'b1;
`endif

  glip_uart_credit_acc #(
    .CREDIT_WIDTH     (CREDIT_WIDTH),
    .CREDIT_THRESHOLD (CREDIT_THRESHOLD)
  ) u_credit_acc (
    .clk       (clk),
    .rst_n     (rst_n),
    .add_i     (credit_add),
    .inc_i     (credit_inc),
    .snap_i    (snap),
    .amt_o     (snap_amt),
    .pending_o (pending),
    .nz_o      (acc_nz)
  );

  // A done pulse only counts while a byte is actually on the wire.
  assign gap = tx_done & tx_en_q & (state_q != IDLE);

  always_comb begin
    state_d    = state_q;
    byte_d     = byte_q;
    amt_d      = amt_q;
    last_d     = last_q;
    data_ready = 1'b0;
    snap       = 1'b0;

    case (state_q)
      IDLE: begin
        // Credit wins unless it just went out and data is waiting (starvation guard).
        if (pending && (!last_q || !data_valid)) begin
          snap    = 1'b1;
          amt_d   = snap_amt;
          last_d  = 1'b1;
          state_d = C_ESC;
        end else if (data_valid) begin
          byte_d     = data_in;
          data_ready = 1'b1;
          last_d     = 1'b0;
          state_d    = (data_in == ESC) ? D_DUP : D_BYTE;
        end
      end
      D_DUP:   if (gap) state_d = D_BYTE;
      D_BYTE:  if (gap) state_d = IDLE;
      C_ESC:   if (gap) state_d = C_HI;
      C_HI:    if (gap) state_d = C_LO;
      C_LO:    if (gap) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // CTS is sampled only at byte start; a running byte holds enable until done.
    tx_en_d = (state_d != IDLE) && !gap && (tx_en_q || cts_ok);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      byte_q  <= 8'h00;
      amt_q   <= 14'd0;
      last_q  <= 1'b0;
      tx_en_q <= 1'b0;
    end else begin
      state_q <= state_d;
      byte_q  <= byte_d;
      amt_q   <= amt_d;
      last_q  <= last_d;
      tx_en_q <= tx_en_d;
    end
  end

  always_comb begin
    tx_data = 8'h00;
    case (state_q)
      D_DUP, C_ESC: tx_data = ESC;
      D_BYTE:       tx_data = byte_q;
      C_HI:         tx_data = {2'b01, amt_q[13:8]};
      C_LO:         tx_data = amt_q[7:0];
      default:      tx_data = 8'h00;
    endcase
  end

  assign tx_enable = tx_en_q;
  assign busy      = (state_q != IDLE) | acc_nz;

endmodule

// File: tb/tb_glip_uart_tx_scheduler.sv
// Directed bench for glip_uart_tx_scheduler with a 10-cycle transmitter model.
module tb_glip_uart_tx_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  data_in;
  logic        data_valid;
  logic        data_ready;
  logic        credit_add;
  logic [15:0] credit_inc;
  logic [7:0]  tx_data;
  logic        tx_enable;
  logic        tx_done;
  logic        uart_cts_n;
  logic        busy;

  glip_uart_tx_scheduler #(
    .CREDIT_WIDTH     (16),
    .CREDIT_THRESHOLD (64)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .credit_add (credit_add),
    .credit_inc (credit_inc),
    .tx_data    (tx_data),
    .tx_enable  (tx_enable),
    .tx_done    (tx_done),
    .uart_cts_n (uart_cts_n),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0] txlog[$];
  logic [7:0] src_q[$];
  int rdy_cnt   = 0;
  int gap_err   = 0;
  int hold_err  = 0;
  int en_cycles = 0;
  int done_cnt  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Transmitter model: logs each byte at start, pulses tx_done after 10 enabled cycles.
  initial begin
    int         cnt;
    logic       prev_en;
    logic [7:0] cur;
    cnt = 0; prev_en = 1'b0; cur = 8'h00;
    tx_done = 1'b0;
    forever begin
      @(negedge clk);
      tx_done = 1'b0;
      if (!rst_n) begin
        cnt = 0;
        prev_en = 1'b0;
      end else begin
        if (tx_enable) begin
          en_cycles++;
          if (cnt == 0) begin
            txlog.push_back(tx_data);
            cur = tx_data;
            if (prev_en) gap_err++;
          end else if (tx_data !== cur) begin
            hold_err++;
          end
          cnt++;
          if (cnt == 10) begin
            tx_done = 1'b1;
            done_cnt++;
            cnt = 0;
          end
        end else begin
          cnt = 0;
        end
        prev_en = tx_enable;
      end
    end
  end

  // Data source: presents queue head, pops when data_ready is seen.
  initial begin
    data_valid = 1'b0;
    data_in    = 8'h00;
    forever begin
      @(negedge clk);
      if (rst_n && src_q.size() > 0) begin
        data_valid = 1'b1;
        data_in    = src_q[0];
      end else begin
        data_valid = 1'b0;
      end
      #1;
      if (data_ready) begin
        rdy_cnt++;
        if (src_q.size() > 0) void'(src_q.pop_front());
      end
    end
  end

  task automatic wait_bytes(input int n, input int budget);
    int c;
    c = 0;
    while (txlog.size() < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk("wait_bytes", 32'(txlog.size() >= n), 32'd1);
  endtask

  task automatic wait_idle(input int budget);
    int c;
    c = 0;
    while ((busy || tx_enable) && c < budget) begin
      @(negedge clk);
      c++;
    end
    #2;
    chk("idle_busy", 32'(busy), 32'd0);
  endtask

  task automatic check_seq(input string tag, input int base, input int n, input logic [95:0] seq);
    for (int i = 0; i < n; i++) begin
      logic [7:0] got;
      got = (base + i < txlog.size()) ? txlog[base + i] : 8'hxx;
      chk($sformatf("%s[%0d]", tag, i), 32'(got), 32'(seq[8*(n-1-i) +: 8]));
    end
  endtask

  task automatic add_credit(input logic [15:0] inc);
    @(negedge clk);
    credit_add = 1'b1;
    credit_inc = inc;
    @(negedge clk);
    credit_add = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int rdy0;
    int en0;
    int d0;
    int k;

    rst_n      = 1'b0;
    credit_add = 1'b0;
    credit_inc = 16'd0;
    uart_cts_n = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    chk("rst_tx_enable", 32'(tx_enable), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'h00);
    chk("rst_data_ready", 32'(data_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Credit frame of 100, no data.
    base = txlog.size();
    @(negedge clk);
    credit_add = 1'b1;
    credit_inc = 16'd100;
    @(negedge clk);
    credit_add = 1'b0;
    #2;
    chk("crd_lat_pre", 32'(tx_enable), 32'd0);
    chk("crd_busy", 32'(busy), 32'd1);
    @(negedge clk);
    #2;
    chk("crd_lat_en", 32'(tx_enable), 32'd1);
    chk("crd_lat_esc", 32'(tx_data), 32'hFE);
    wait_bytes(base + 3, 200);
    #2;
    chk("crd_busy_last", 32'(busy), 32'd1);
    wait_idle(200);
    check_seq("crd100", base, 3, {8'hFE, 8'h40, 8'h64});

    // Data 41, FE, 42.
    base = txlog.size();
    rdy0 = rdy_cnt;
    @(negedge clk);
    #2;
    src_q.push_back(8'h41);
    src_q.push_back(8'hFE);
    src_q.push_back(8'h42);
    @(negedge clk);
    #2;
    chk("dat_ready_c0", 32'(data_ready), 32'd1);
    chk("dat_en_c0", 32'(tx_enable), 32'd0);
    @(negedge clk);
    #2;
    chk("dat_en_c1", 32'(tx_enable), 32'd1);
    chk("dat_byte_c1", 32'(tx_data), 32'h41);
    wait_bytes(base + 4, 300);
    wait_idle(200);
    check_seq("data", base, 4, {8'h41, 8'hFE, 8'hFE, 8'h42});
    chk("ready_pulses", 32'(rdy_cnt - rdy0), 32'd3);

    // acc = 20000 with data streaming: max frame, one byte, remainder frame.
    base = txlog.size();
    @(negedge clk);
    credit_add = 1'b1;
    credit_inc = 16'd20000;
    #2;
    src_q.push_back(8'h11);
    src_q.push_back(8'h12);
    src_q.push_back(8'h13);
    @(negedge clk);
    credit_add = 1'b0;
    wait_bytes(base + 9, 600);
    wait_idle(200);
    check_seq("stream", base, 9,
              {8'hFE, 8'h7F, 8'hFF, 8'h11, 8'hFE, 8'h4E, 8'h21, 8'h12, 8'h13});

    // Add of 70 lands in the snapshot cycle of a 64 frame.
    base = txlog.size();
    @(negedge clk);
    credit_add = 1'b1;
    credit_inc = 16'd64;
    @(negedge clk);
    credit_inc = 16'd70;
    @(negedge clk);
    credit_add = 1'b0;
    wait_bytes(base + 6, 400);
    wait_idle(200);
    check_seq("snap_add", base, 6, {8'hFE, 8'h40, 8'h40, 8'hFE, 8'h40, 8'h46});

    // Reset while the C_HI byte is on the wire.
    base = txlog.size();
    add_credit(16'd100);
    wait_bytes(base + 2, 200);
    #2;
    chk("chi_en", 32'(tx_enable), 32'd1);
    chk("chi_byte", 32'(tx_data), 32'h40);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_en", 32'(tx_enable), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    en0 = en_cycles;
    repeat (30) @(negedge clk);
    #2;
    chk("post_rst_en", 32'(en_cycles - en0), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_bytes", 32'(txlog.size() - base), 32'd2);

`ifdef GLIP_UART_TX_SCHED_CTS_EN
    base = txlog.size();
    @(negedge clk);
    uart_cts_n = 1'b1;
    repeat (4) @(negedge clk);
    add_credit(16'd100);
    en0 = en_cycles;
    repeat (20) @(negedge clk);
    chk("cts_hold_en", 32'(en_cycles - en0), 32'd0);
    chk("cts_hold_busy", 32'(busy), 32'd1);
    uart_cts_n = 1'b0;
    k = 0;
    while (!tx_enable && k < 4) begin
      @(negedge clk);
      k++;
    end
    chk("cts_start", 32'(tx_enable), 32'd1);
    d0 = done_cnt;
    #2;
    uart_cts_n = 1'b1;
    repeat (25) @(negedge clk);
    chk("cts_mid_done", 32'(done_cnt - d0), 32'd1);
    chk("cts_mid_bytes", 32'(txlog.size() - base), 32'd1);
    chk("cts_mid_en", 32'(tx_enable), 32'd0);
    uart_cts_n = 1'b0;
    wait_bytes(base + 3, 200);
    wait_idle(200);
    check_seq("cts", base, 3, {8'hFE, 8'h40, 8'h64});
`endif

    chk("gap_errors", 32'(gap_err), 32'd0);
    chk("hold_errors", 32'(hold_err), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
